// File: rtl/pwm_counter.sv
// -----------------------------------------------------------------------------
// pwm_counter
//
// Timebase stage that sits directly in front of pwm_gen. It produces the
// running count plus the period/compare values that pwm_gen compares against.
//
//   * A prescaler divides clk so that one counter step ("tick") happens every
//     prescale+1 enabled cycles.
//   * The counter runs up (0 .. period, then back to 0) or down
//     (period .. 0, then reload period). A registered one-cycle wrap_pulse
//     marks the cycle in which count_val takes its wrap value.
//   * Optional shadow registers (compile-time macro PWM_CNT_SHADOW_EN) hold
//     period/compare1/compare2 stable for a whole period. New values are
//     picked up only at a wrap, on cnt_clr, or while the counter is disabled,
//     so pwm_gen never sees a mid-period change.
//     Without the macro the *_out ports are a plain pass-through of *_in.
//
// Parameters
//   CNT_W   width of count_val, period and compare values
//   PSC_W   width of the prescale value and of the internal prescaler counter
//
// Ports
//   clk           in   1      peripheral clock, rising edge
//   rst           in   1      asynchronous reset, active-high
//   cnt_en        in   1      1 = count, 0 = freeze counter and prescaler
//   cnt_clr       in   1      synchronous clear, wins over counting
//   count_up      in   1      1 = up-count, 0 = down-count
//   prescale      in   PSC_W  tick every prescale+1 clk cycles
//   period_in     in   CNT_W  terminal value from the register file
//   compare1_in   in   CNT_W  compare1 from the register file
//   compare2_in   in   CNT_W  compare2 from the register file
//   count_val     out  CNT_W  registered counter value
//   period_out    out  CNT_W  effective period
//   compare1_out  out  CNT_W  effective compare1
//   compare2_out  out  CNT_W  effective compare2
//   wrap_pulse    out  1      one-cycle strobe when count_val takes its wrap value
// -----------------------------------------------------------------------------
module pwm_counter #(
  parameter int CNT_W = 16,
  parameter int PSC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt_en,
  input  logic             cnt_clr,
  input  logic             count_up,
  input  logic [PSC_W-1:0] prescale,
  input  logic [CNT_W-1:0] period_in,
  input  logic [CNT_W-1:0] compare1_in,
  input  logic [CNT_W-1:0] compare2_in,
  output logic [CNT_W-1:0] count_val,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] compare1_out,
  output logic [CNT_W-1:0] compare2_out,
  output logic             wrap_pulse
);

  // Terminal value the counter actually works against: the shadowed period
  // when shadowing is built, otherwise the live register-file value.
  logic [CNT_W-1:0] period_eff;

  logic [PSC_W-1:0] psc_cnt;
  logic [PSC_W-1:0] psc_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             wrap_nxt;
  logic             tick;
  logic             wrap_evt;

  // ---------------------------------------------------------------------------
  // Prescaler tick and wrap detection
  // ---------------------------------------------------------------------------
  // ">=" rather than "==" so that lowering prescale below the current
  // prescaler count still produces a tick on the next cycle instead of
  // running the prescaler all the way around.
  assign tick = cnt_en && (psc_cnt >= prescale);

  // Up: anything at or above the period wraps, which also pulls the counter
  // back into range after the period was lowered below count_val.
  // Down: wrap (reload) when the counter has reached zero.
  assign wrap_evt = tick && (count_up ? (count_val >= period_eff)
                                      : (count_val == '0));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    psc_nxt   = psc_cnt;
    count_nxt = count_val;
    wrap_nxt  = 1'b0;

    if (cnt_clr) begin
      // Clear beats a coincident tick; wrap_pulse stays low.
      psc_nxt   = '0;
      count_nxt = '0;
    end else if (cnt_en) begin
      psc_nxt = tick ? '0 : psc_cnt + PSC_W'(1);
      if (tick) begin
        wrap_nxt = wrap_evt;
        if (count_up) begin
          count_nxt = wrap_evt ? '0 : count_val + CNT_W'(1);
        end else begin
          count_nxt = wrap_evt ? period_eff : count_val - CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Counter state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (rst) begin
      psc_cnt    <= '0;
      count_val  <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      psc_cnt    <= psc_nxt;
      count_val  <= count_nxt;
      wrap_pulse <= wrap_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Period / compare values handed to pwm_gen
  // ---------------------------------------------------------------------------
`ifdef PWM_CNT_SHADOW_EN
  // Reload on the same edge that sets wrap_pulse, on clear, and continuously
  // while disabled so a freshly enabled counter starts with current values.
  logic shadow_load;

  assign shadow_load = wrap_evt || cnt_clr || !cnt_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_out   <= '0;
      compare1_out <= '0;
      compare2_out <= '0;
    end else if (shadow_load) begin
      period_out   <= period_in;
      compare1_out <= compare1_in;
      compare2_out <= compare2_in;
    end
  end

  assign period_eff = period_out;
`else
  // No shadowing: register-file writes take effect immediately.
  assign period_out   = period_in;
  assign compare1_out = compare1_in;
  assign compare2_out = compare2_in;
  assign period_eff   = period_in;
`endif

endmodule

// File: tb/tb_pwm_counter.sv
// -----------------------------------------------------------------------------
// tb_pwm_counter
//
// Directed bench for pwm_counter. Inputs change on the falling edge, outputs
// are sampled on the falling edge (half a cycle after the active edge).
// Build with or without PWM_CNT_SHADOW_EN; the shadow-specific section and
// reset-value expectations follow the macro.
// -----------------------------------------------------------------------------
module tb_pwm_counter;

  localparam int CNT_W = 16;
  localparam int PSC_W = 8;

  logic             clk;
  logic             rst;
  logic             cnt_en;
  logic             cnt_clr;
  logic             count_up;
  logic [PSC_W-1:0] prescale;
  logic [CNT_W-1:0] period_in;
  logic [CNT_W-1:0] compare1_in;
  logic [CNT_W-1:0] compare2_in;
  logic [CNT_W-1:0] count_val;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] compare1_out;
  logic [CNT_W-1:0] compare2_out;
  logic             wrap_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  // Hand-computed sequences, one entry per falling edge after enabling.
  localparam int T1_CNT [6]  = '{1, 2, 3, 4, 0, 1};
  localparam int T1_WRP [6]  = '{0, 0, 0, 0, 1, 0};
  localparam int T2_CNT [18] = '{0, 0, 1, 1, 1, 2, 2, 2, 0,
                                 0, 0, 1, 1, 1, 2, 2, 2, 0};
  localparam int T2_WRP [18] = '{0, 0, 0, 0, 0, 0, 0, 0, 1,
                                 0, 0, 0, 0, 0, 0, 0, 0, 1};
  localparam int T3_CNT [5]  = '{3, 2, 1, 0, 3};
  localparam int T3_WRP [5]  = '{1, 0, 0, 0, 1};

`ifdef PWM_CNT_SHADOW_EN
  localparam int RST_PERIOD = 0;
  localparam int RST_CMP1   = 0;
`else
  localparam int RST_PERIOD = 4;
  localparam int RST_CMP1   = 1;
`endif

  pwm_counter #(
    .CNT_W(CNT_W),
    .PSC_W(PSC_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cnt_en       (cnt_en),
    .cnt_clr      (cnt_clr),
    .count_up     (count_up),
    .prescale     (prescale),
    .period_in    (period_in),
    .compare1_in  (compare1_in),
    .compare2_in  (compare2_in),
    .count_val    (count_val),
    .period_out   (period_out),
    .compare1_out (compare1_out),
    .compare2_out (compare2_out),
    .wrap_pulse   (wrap_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Clear with the counter disabled; also loads the shadow registers.
  task automatic clear_idle();
    cnt_clr = 1'b1;
    cnt_en  = 1'b0;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    cnt_en      = 1'b0;
    cnt_clr     = 1'b0;
    count_up    = 1'b1;
    prescale    = '0;
    period_in   = 16'd4;
    compare1_in = 16'd1;
    compare2_in = 16'd3;

    // Reset state
    @(negedge clk);
    check("rst_cnt", count_val, 0);
    check("rst_wrap", wrap_pulse, 0);
    check("rst_period", period_out, RST_PERIOD);
    check("rst_cmp1", compare1_out, RST_CMP1);
    rst = 1'b0;
    @(negedge clk);
    check("idle_cnt", count_val, 0);
    check("idle_period", period_out, 4);

    // T1: up, prescale 0, period 4
    cnt_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("t1_cnt%0d", i), count_val, T1_CNT[i]);
      check($sformatf("t1_wrap%0d", i), wrap_pulse, T1_WRP[i]);
    end

    // T2: up, prescale 2, period 2
    prescale  = 8'd2;
    period_in = 16'd2;
    clear_idle();
    check("t2_clr_cnt", count_val, 0);
    cnt_en = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      check($sformatf("t2_cnt%0d", i), count_val, T2_CNT[i]);
      check($sformatf("t2_wrap%0d", i), wrap_pulse, T2_WRP[i]);
    end

    // T3: down, prescale 0, period 3, starting at 0
    count_up  = 1'b0;
    prescale  = 8'd0;
    period_in = 16'd3;
    clear_idle();
    cnt_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t3_cnt%0d", i), count_val, T3_CNT[i]);
      check($sformatf("t3_wrap%0d", i), wrap_pulse, T3_WRP[i]);
    end

    // T4: clear coincident with a tick, then hold while disabled
    count_up  = 1'b1;
    prescale  = 8'd1;
    period_in = 16'd9;
    clear_idle();
    cnt_en = 1'b1;
    repeat (4) @(negedge clk);
    check("t4_pre_cnt", count_val, 2);
    @(negedge clk);
    check("t4_pre_cnt2", count_val, 2);
    cnt_clr = 1'b1;
    @(negedge clk);
    check("t4_clr_cnt", count_val, 0);
    check("t4_clr_wrap", wrap_pulse, 0);
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t4_hold%0d", i), count_val, 0);
    end
    cnt_en = 1'b1;
    @(negedge clk);
    check("t4_resume0", count_val, 0);
    @(negedge clk);
    check("t4_resume1", count_val, 1);
    cnt_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t4_hold1_%0d", i), count_val, 1);
    end
    cnt_en = 1'b1;
    repeat (2) @(negedge clk);
    check("t4_resume2", count_val, 2);

`ifdef PWM_CNT_SHADOW_EN
    // T5: mid-period write invisible until the wrap
    prescale    = 8'd0;
    period_in   = 16'd5;
    compare1_in = 16'd2;
    compare2_in = 16'd4;
    @(negedge clk);
    check("t5_cnt3", count_val, 3);
    check("t5_period_old", period_out, 9);
    check("t5_cmp1_old", compare1_out, 1);
    repeat (5) @(negedge clk);
    @(negedge clk);
    check("t5_cnt9", count_val, 9);
    check("t5_period_old2", period_out, 9);
    @(negedge clk);
    check("t5_wrap_cnt", count_val, 0);
    check("t5_wrap", wrap_pulse, 1);
    check("t5_period_new", period_out, 5);
    check("t5_cmp1_new", compare1_out, 2);
    check("t5_cmp2_new", compare2_out, 4);
    repeat (4) @(negedge clk);
    @(negedge clk);
    check("t5_cnt5", count_val, 5);
    @(negedge clk);
    check("t5_wrap2_cnt", count_val, 0);
    check("t5_wrap2", wrap_pulse, 1);
    repeat (3) @(negedge clk);
`else
    // T6: write takes effect at once, over-period count wraps next tick
    prescale = 8'd0;
    repeat (5) @(negedge clk);
    check("t6_cnt7", count_val, 7);
    period_in   = 16'd5;
    compare1_in = 16'd2;
    compare2_in = 16'd4;
    #1;
    check("t6_period_now", period_out, 5);
    check("t6_cmp1_now", compare1_out, 2);
    check("t6_cmp2_now", compare2_out, 4);
    @(negedge clk);
    check("t6_wrap_cnt", count_val, 0);
    check("t6_wrap", wrap_pulse, 1);
    repeat (3) @(negedge clk);
`endif
    check("t7_pre_cnt", count_val, 3);

    // T7: asynchronous reset mid-count
    #2;
    rst    = 1'b1;
    cnt_en = 1'b0;
    #1;
    check("t7_rst_cnt", count_val, 0);
    check("t7_rst_wrap", wrap_pulse, 0);
`ifdef PWM_CNT_SHADOW_EN
    check("t7_rst_period", period_out, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t7_post_cnt", count_val, 0);
    cnt_en = 1'b1;
    @(negedge clk);
    check("t7_resume", count_val, 1);

    // T8: period 0 wraps on every tick, clear suppresses the wrap
    period_in = 16'd0;
    clear_idle();
    cnt_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t8_cnt%0d", i), count_val, 0);
      check($sformatf("t8_wrap%0d", i), wrap_pulse, 1);
    end
    cnt_clr = 1'b1;
    @(negedge clk);
    check("t8_clr_wrap", wrap_pulse, 0);
    cnt_clr = 1'b0;

    // T9: prescale lowered below the prescaler count ticks next cycle
    period_in = 16'd9;
    prescale  = 8'd5;
    clear_idle();
    cnt_en = 1'b1;
    repeat (3) @(negedge clk);
    check("t9_pre_cnt", count_val, 0);
    prescale = 8'd1;
    @(negedge clk);
    check("t9_tick_cnt", count_val, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
